// File: rtl/braille_page_reader.sv
// rtl/braille_page_reader.sv - buffered multi-cell braille page reader
//
// Purpose: stores a string of braille cells delivered by the converter and
// presents it CELLS cells at a time. The user pages through it with the next
// and prev buttons. A START marker page precedes the text and an END marker
// page follows it.
//
// Ports:
//   clk         clock
//   reset       asynchronous active-low reset
//   load_start  begin a load (honoured in IDLE only)
//   load_len    characters to load, 0..DEPTH (larger values clip to DEPTH)
//   load_data   character from the converter
//   load_valid  load_data valid
//   load_ready  high while in LOAD
//   next, prev  asynchronous buttons, acted on at their falling edge
//   cells_out   registered cell patterns, cell k at [k*CELL_W +: CELL_W]
//   page_base   buffer index shown on cell 0
//   busy        high in every state but IDLE
//   at_end      high in END
module braille_page_reader #(
  parameter int                 CELL_W     = 8,
  parameter int                 CELLS      = 4,
  parameter int                 DEPTH      = 256,
  parameter int                 AW         = 8,
  parameter logic [CELL_W-1:0]  START_CODE = 'h17,
  parameter logic [CELL_W-1:0]  END_CODE   = 'h01,
  parameter logic [CELL_W-1:0]  BLANK_CODE = 'h00
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_start,
  input  logic [AW:0]               load_len,
  input  logic [CELL_W-1:0]         load_data,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic                      next,
  input  logic                      prev,
  output logic [CELLS*CELL_W-1:0]   cells_out,
  output logic [AW-1:0]             page_base,
  output logic                      busy,
  output logic                      at_end
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_SHOW,
    S_END
  } state_t;

  // Lengths and indices are AW+1 bits wide so that a full buffer (DEPTH)
  // is representable and page_base+CELLS never wraps in comparisons.
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CELLS_L = (AW+1)'(CELLS);
  localparam logic [AW:0]   ONE_L   = (AW+1)'(1);
  localparam logic [AW-1:0] CELLS_A = AW'(CELLS);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [AW-1:0]            r_page_base;
  logic [AW-1:0]            w_pb_nxt;
  logic [AW:0]              r_len;
  logic [AW:0]              w_len_nxt;
  logic [AW:0]              r_wr;
  logic [AW:0]              w_wr_nxt;
  logic                     w_we;
  logic [CELLS*CELL_W-1:0]  r_cells;
  logic [CELLS*CELL_W-1:0]  w_cells_nxt;
  logic [CELLS*CELL_W-1:0]  w_show_cells;
  logic [AW:0]              w_len_clip;
  logic [AW:0]              w_pb_plus;
  logic [AW-1:0]            w_last_pb;

  logic [CELL_W-1:0]        r_mem [DEPTH];

  // Button conditioning: two synchroniser flops plus a delayed copy of the
  // synchronised level. A falling edge shows up as a one-cycle pulse.
  logic r_next_s1, r_next_s2, r_next_d;
  logic r_prev_s1, r_prev_s2, r_prev_d;
  logic w_next_fall, w_prev_fall;
  logic w_next_ev, w_prev_ev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_next_s1 <= 1'b0;
      r_next_s2 <= 1'b0;
      r_next_d  <= 1'b0;
      r_prev_s1 <= 1'b0;
      r_prev_s2 <= 1'b0;
      r_prev_d  <= 1'b0;
    end else begin
      r_next_s1 <= next;
      r_next_s2 <= r_next_s1;
      r_next_d  <= r_next_s2;
      r_prev_s1 <= prev;
      r_prev_s2 <= r_prev_s1;
      r_prev_d  <= r_prev_s2;
    end
  end

  assign w_next_fall = r_next_d & ~r_next_s2;
  assign w_prev_fall = r_prev_d & ~r_prev_s2;
  // Simultaneous releases are ambiguous, so neither is acted on.
  assign w_next_ev   = w_next_fall & ~w_prev_fall;
  assign w_prev_ev   = w_prev_fall & ~w_next_fall;

  // Text buffer: written only during LOAD, never reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_wr[AW-1:0]] <= load_data;
    end
  end

  assign w_len_clip = (load_len > DEPTH_L) ? DEPTH_L : load_len;
  assign w_pb_plus  = {1'b0, r_page_base} + CELLS_L;
  // First index of the last (possibly partial) page; only used when len>0.
  assign w_last_pb  = AW'(((r_len - ONE_L) / CELLS_L) * CELLS_L);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_page_base <= '0;
      r_len       <= '0;
      r_wr        <= '0;
      r_cells     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_page_base <= w_pb_nxt;
      r_len       <= w_len_nxt;
      r_wr        <= w_wr_nxt;
      r_cells     <= w_cells_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pb_nxt    = r_page_base;
    w_len_nxt   = r_len;
    w_wr_nxt    = r_wr;
    w_we        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load_start) begin
          w_len_nxt = w_len_clip;
          w_wr_nxt  = '0;
          w_pb_nxt  = '0;
          w_state_nxt = (w_len_clip != '0) ? S_LOAD : S_START;
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          w_we     = 1'b1;
          w_wr_nxt = r_wr + ONE_L;
          if (r_wr + ONE_L == r_len) begin
            w_state_nxt = S_START;
            w_pb_nxt    = '0;
          end
        end
      end
      S_START: begin
        if (w_next_ev) begin
          w_pb_nxt    = '0;
          w_state_nxt = (r_len == '0) ? S_END : S_SHOW;
        end
      end
      S_SHOW: begin
        if (w_next_ev) begin
          if (w_pb_plus >= r_len) begin
            w_state_nxt = S_END;
          end else begin
            w_pb_nxt = r_page_base + CELLS_A;
          end
        end else if (w_prev_ev) begin
          if (r_page_base == '0) begin
            w_state_nxt = S_START;
          end else begin
            w_pb_nxt = r_page_base - CELLS_A;
          end
        end
      end
      S_END: begin
        if (w_next_ev) begin
          w_state_nxt = S_IDLE;
        end else if (w_prev_ev) begin
          if (r_len == '0) begin
            w_state_nxt = S_START;
            w_pb_nxt    = '0;
          end else begin
            w_state_nxt = S_SHOW;
            w_pb_nxt    = w_last_pb;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Combinational buffer read for every cell of the current page. Indices at
  // or past len select BLANK_CODE, so out-of-text entries are never shown.
  for (genvar k = 0; k < CELLS; k++) begin : g_cell
    logic [AW:0] w_idx;
    assign w_idx = {1'b0, r_page_base} + (AW+1)'(k);
    assign w_show_cells[k*CELL_W +: CELL_W] =
      (w_idx < r_len) ? r_mem[w_idx[AW-1:0]] : BLANK_CODE;
  end

  // Cells follow the registered state and page, giving a fixed one-cycle
  // latency from any page change. IDLE and LOAD keep the last pattern.
  always_comb begin
    w_cells_nxt = r_cells;
    case (r_state)
      S_START: w_cells_nxt = {CELLS{START_CODE}};
      S_SHOW:  w_cells_nxt = w_show_cells;
      S_END:   w_cells_nxt = {CELLS{END_CODE}};
      default: w_cells_nxt = r_cells;
    endcase
  end

  assign cells_out  = r_cells;
  assign page_base  = r_page_base;
  assign busy       = (r_state != S_IDLE);
  assign at_end     = (r_state == S_END);
  assign load_ready = (r_state == S_LOAD);

endmodule

// File: tb/tb_braille_page_reader.sv
// tb/tb_braille_page_reader.sv - self-checking bench for braille_page_reader
module tb_braille_page_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [8:0]  load_len;
  logic [7:0]  load_data;
  logic        load_valid;
  logic        load_ready;
  logic        next;
  logic        prev;
  logic [31:0] cells_out;
  logic [7:0]  page_base;
  logic        busy;
  logic        at_end;

  braille_page_reader dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_len   (load_len),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .next       (next),
    .prev       (prev),
    .cells_out  (cells_out),
    .page_base  (page_base),
    .busy       (busy),
    .at_end     (at_end)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which page is on the display, by name.
  localparam int M_IDLE  = 0;
  localparam int M_START = 1;
  localparam int M_TEXT  = 2;
  localparam int M_END   = 3;

  int          m_st;
  int          m_pb;
  int          m_len;
  logic [7:0]  m_mem [256];
  logic [31:0] m_cells;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] page_view();
    logic [31:0] v;
    v = m_cells;
    if (m_st == M_START) v = 32'h17171717;
    else if (m_st == M_END) v = 32'h01010101;
    else if (m_st == M_TEXT) begin
      for (int k = 0; k < 4; k++)
        v[k*8 +: 8] = (m_pb + k < m_len) ? m_mem[m_pb + k] : 8'h00;
    end
    return v;
  endfunction

  task automatic model_press(input bit nx, input bit pv);
    if (nx) begin
      if (m_st == M_START) begin
        m_pb = 0;
        m_st = (m_len == 0) ? M_END : M_TEXT;
      end else if (m_st == M_TEXT) begin
        if (m_pb + 4 >= m_len) m_st = M_END;
        else m_pb = m_pb + 4;
      end else if (m_st == M_END) begin
        m_st = M_IDLE;
      end
    end else if (pv) begin
      if (m_st == M_TEXT) begin
        if (m_pb == 0) m_st = M_START;
        else m_pb = m_pb - 4;
      end else if (m_st == M_END) begin
        if (m_len == 0) begin
          m_st = M_START;
          m_pb = 0;
        end else begin
          m_st = M_TEXT;
          m_pb = ((m_len - 1) / 4) * 4;
        end
      end
    end
    m_cells = page_view();
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".cells"}, cells_out, m_cells);
    check({tag, ".base"}, page_base, m_pb);
    check({tag, ".busy"}, busy, m_st != M_IDLE);
    check({tag, ".end"}, at_end, m_st == M_END);
  endtask

  task automatic press(input string tag, input bit nx, input bit pv);
    next = nx;
    prev = pv;
    repeat (4) tick();
    next = 1'b0;
    prev = 1'b0;
    repeat (6) tick();
    model_press(nx && !pv, pv && !nx);
    check_outs(tag);
  endtask

  task automatic do_load(input int len_in, input bit seq, input bit throttle, input bit poke);
    int len;
    int acc;
    int cyc;
    logic lr;
    len = (len_in > 256) ? 256 : len_in;
    for (int i = 0; i < len; i++)
      m_mem[i] = seq ? 8'(8'h11 + i) : 8'($urandom);
    load_len   = 9'(len_in);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < len && cyc < len * 4 + 40) begin
      load_valid = throttle ? (cyc % 2 == 0) : 1'b1;
      load_data  = (acc < 256) ? m_mem[acc] : 8'h00;
      if (poke) next = (cyc >= 2 && cyc < 4);
      lr = load_ready;
      tick();
      if (load_valid && lr) acc++;
      cyc++;
    end
    load_valid = 1'b0;
    next       = 1'b0;
    check("load.beats", acc, len);
    check("load.ready_drop", load_ready, 1'b0);
    m_len = len;
    m_st  = M_START;
    m_pb  = 0;
    m_cells = page_view();
    repeat (2) tick();
    check_outs("load.start");
  endtask

  initial begin
    reset      = 1'b0;
    load_start = 1'b0;
    load_len   = '0;
    load_data  = '0;
    load_valid = 1'b0;
    next       = 1'b0;
    prev       = 1'b0;
    m_st = M_IDLE; m_pb = 0; m_len = 0; m_cells = 32'h0;
    repeat (3) tick();
    check_outs("reset");
    check("reset.ready", load_ready, 1'b0);
    reset = 1'b1;
    tick();

    // Six characters, forward through the pages then back.
    do_load(6, 1'b1, 1'b0, 1'b0);
    check("tp.start", cells_out, 32'h17171717);
    press("tp.n1", 1, 0);
    check("tp.p0", cells_out, 32'h14131211);
    press("tp.n2", 1, 0);
    check("tp.p1", cells_out, 32'h00001615);
    press("tp.n3", 1, 0);
    check("tp.end", cells_out, 32'h01010101);
    check("tp.at_end", at_end, 1'b1);
    press("tp.b1", 0, 1);
    check("tp.back1", cells_out, 32'h00001615);
    press("tp.b2", 0, 1);
    check("tp.back0", cells_out, 32'h14131211);
    press("tp.b3", 0, 1);
    check("tp.backstart", cells_out, 32'h17171717);
    press("tp.b4", 0, 1);
    check("tp.stay", cells_out, 32'h17171717);

    // Release timing: acted on at the third edge after the fall, exactly once.
    press("tm.n0", 1, 0);
    next = 1'b1;
    repeat (4) tick();
    next = 1'b0;
    tick();
    check("tm.e1", page_base, 8'd0);
    tick();
    check("tm.e2", page_base, 8'd0);
    tick();
    check("tm.e3", page_base, 8'd4);
    repeat (6) tick();
    model_press(1, 0);
    check_outs("tm.once");

    // Simultaneous release, and load_start while showing text.
    press("both", 1, 1);
    load_len   = 9'd5;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    repeat (3) tick();
    check_outs("ls_show");

    press("tp.n4", 1, 0);
    press("tp.idle", 1, 0);
    check("tp.idle_busy", busy, 1'b0);
    check("tp.idle_hold", cells_out, 32'h01010101);

    // Empty text.
    do_load(0, 1'b0, 1'b0, 1'b0);
    press("z.n", 1, 0);
    press("z.p", 0, 1);
    press("z.n2", 1, 0);
    press("z.idle", 1, 0);

    // Throttled five-beat load, then a long load with a button poke inside.
    do_load(5, 1'b1, 1'b1, 1'b0);
    press("thr.n", 1, 0);
    press("thr.n2", 1, 0);
    check("thr.tail", cells_out, 32'h00000015);
    press("thr.n3", 1, 0);
    press("thr.idle", 1, 0);
    do_load(20, 1'b0, 1'b1, 1'b1);
    press("poke.n", 1, 0);

    // Reset while showing text.
    reset = 1'b0;
    #1;
    check("rst.cells", cells_out, 32'h0);
    check("rst.busy", busy, 1'b0);
    check("rst.base", page_base, 8'd0);
    tick();
    reset = 1'b1;
    m_st = M_IDLE; m_pb = 0; m_cells = 32'h0;
    tick();
    check_outs("rst.after");

    // Full buffer, via an oversize length that clips to DEPTH.
    do_load(300, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 64; p++) press("full.n", 1, 0);
    check("full.last_base", page_base, 8'd252);
    press("full.end", 1, 0);
    press("full.back", 0, 1);
    press("full.end2", 1, 0);
    press("full.idle", 1, 0);

    // Random loads and navigation.
    for (int it = 0; it < 8; it++) begin
      do_load($urandom_range(0, 40), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      for (int j = 0; j < 20; j++) begin
        int r;
        if (m_st == M_IDLE) break;
        r = $urandom_range(0, 9);
        if (r < 6) press("rnd.n", 1, 0);
        else if (r < 9) press("rnd.p", 0, 1);
        else press("rnd.b", 1, 1);
      end
      while (m_st != M_IDLE) press("rnd.drain", 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
